// File: rtl/model_dma_pkg.sv
// Shared definitions for the model DMA path (transmit and receive sides).
package model_dma_pkg;

  localparam int AXIS_DATA_W       = 32;
  localparam int DEFAULT_FRAME_LEN = 4096;

  // One AXI4-Stream beat as seen by either side of the DMA path.
  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic                   last;
  } axis_beat_t;

  // Occupancy of the single-stage output register in front of the stream port.
  typedef enum logic {
    REG_EMPTY = 1'b0,
    REG_FULL  = 1'b1
  } out_reg_state_t;

  // Counter width that stays legal for a range of exactly one value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and an occupancy count.
// The head word is visible combinationally whenever the FIFO is not empty.
module sync_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 64,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_next;
  logic              do_push;
  logic              do_pop;

  // A write into a full FIFO is ignored here; the caller flags it as overflow.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Occupancy after this cycle's push/pop; a simultaneous pair leaves it unchanged.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CW'(1);
    end else if (!do_push && do_pop) begin
      count_next = count - CW'(1);
    end
  end

  // Storage write port.
  // NOTE: the data array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, count and flags; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/result_axis_tx.sv
// Transmit side of the model DMA path: buffers model output words in a FIFO and
// presents them on an AXI4-Stream master with tlast on the final beat of each frame.
module result_axis_tx
  import model_dma_pkg::*;
#(
  parameter int DATA_W       = AXIS_DATA_W,
  parameter int FIFO_DEPTH   = 64,
  parameter int FRAME_LEN    = DEFAULT_FRAME_LEN,
  parameter int AFULL_MARGIN = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_stall,
  output logic [DATA_W-1:0]           m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        frame_done,
  output logic                        overflow,
  input  logic                        clear_overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = cnt_width(FRAME_LEN);
  localparam logic [CW-1:0] AFULL_LEVEL = CW'(FIFO_DEPTH - AFULL_MARGIN);
  localparam logic [BW-1:0] LAST_BEAT   = BW'(FRAME_LEN - 1);

  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  out_reg_state_t    state;
  out_reg_state_t    state_next;
  logic              load;
  logic              handshake;
  logic [BW-1:0]     beat_cnt;
  logic              at_last;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (load),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // tvalid comes straight from the register state, never from tready.
  assign m_axis_tvalid = (state == REG_FULL);
  assign handshake     = m_axis_tvalid && m_axis_tready;
  assign at_last       = (beat_cnt == LAST_BEAT);
  // The beat counter only moves on a handshake, so tlast is stable while stalled.
  assign m_axis_tlast  = m_axis_tvalid && at_last;

  // Output register occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= REG_EMPTY;
    else        state <= state_next;
  end

  // Refill from the FIFO head when empty or when the current beat is accepted.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      REG_EMPTY: begin
        if (!fifo_empty) begin
          load       = 1'b1;
          state_next = REG_FULL;
        end
      end
      REG_FULL: begin
        if (m_axis_tready) begin
          if (!fifo_empty) load = 1'b1;
          else             state_next = REG_EMPTY;
        end
      end
      default: state_next = REG_EMPTY;
    endcase
  end

  // Output data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    m_axis_tdata <= '0;
    else if (load) m_axis_tdata <= fifo_head;
  end

  // Beat position within the frame of the word held in the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (handshake) begin
      beat_cnt <= at_last ? '0 : beat_cnt + BW'(1);
    end
  end

  // One-cycle pulse following the handshake that carried tlast.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_done <= 1'b0;
    else        frame_done <= handshake && at_last;
  end

  // Almost-full throttle; the margin covers words still draining from the model.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_stall <= 1'b0;
    else        in_stall <= (fifo_count >= AFULL_LEVEL);
  end

  // Sticky overflow; a new dropped word takes priority over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      overflow <= 1'b0;
    else if (in_valid && fifo_full)  overflow <= 1'b1;
    else if (clear_overflow)         overflow <= 1'b0;
  end

endmodule

// File: tb/tb_result_axis_tx.sv
// Directed bench for result_axis_tx with FRAME_LEN=16 and a 64-entry FIFO.
module tb_result_axis_tx;

  localparam int DATA_W       = 32;
  localparam int FIFO_DEPTH   = 64;
  localparam int FRAME_LEN    = 16;
  localparam int AFULL_MARGIN = 8;
  localparam int CW           = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_stall;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              frame_done;
  logic              overflow;
  logic              clear_overflow;
  logic [CW-1:0]     fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  result_axis_tx #(
    .DATA_W       (DATA_W),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .FRAME_LEN    (FRAME_LEN),
    .AFULL_MARGIN (AFULL_MARGIN)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_stall       (in_stall),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .frame_done     (frame_done),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; m_axis_tready = 1'b0; clear_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; m_axis_tready = 1'b0; clear_overflow = 1'b0;
    #2;
    n_cmp++;
    if ({m_axis_tvalid, m_axis_tlast, frame_done, overflow, in_stall} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 00000",
               {m_axis_tvalid, m_axis_tlast, frame_done, overflow, in_stall});
    end
    n_cmp++;
    if (m_axis_tdata !== 32'h0) begin
      n_err++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata);
    end
    n_cmp++;
    if (fifo_count !== 7'd0) begin
      n_err++; $display("FAIL reset_count: got %0d want 0", fifo_count);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // 16 words back to back with tready high: in-order beats, latency 2, one frame.
  task automatic test_basic_frame();
    int first = -1, nbeat = 0, ndone = 0, done_cyc = -1;
    bit gap = 1'b0;
    m_axis_tready = 1'b1;
    for (int c = 0; c < 26; c++) begin
      tick();
      in_valid = (c < 16);
      in_data  = 32'(c + 1);
      @(negedge clk);
      if (m_axis_tvalid) begin
        if (first < 0) first = c;
        n_cmp++;
        if (m_axis_tdata !== 32'(nbeat + 1)) begin
          n_err++; $display("FAIL basic_data[%0d]: got %h want %h", nbeat, m_axis_tdata, nbeat + 1);
        end
        n_cmp++;
        if (m_axis_tlast !== (nbeat == 15)) begin
          n_err++; $display("FAIL basic_tlast[%0d]: got %b want %b", nbeat, m_axis_tlast, nbeat == 15);
        end
        nbeat++;
      end else if (first >= 0 && nbeat < 16) begin
        gap = 1'b1;
      end
      if (frame_done) begin
        ndone++; done_cyc = c;
      end
    end
    n_cmp++;
    if (first !== 2) begin n_err++; $display("FAIL basic_latency: got %0d want 2", first); end
    n_cmp++;
    if (nbeat !== 16) begin n_err++; $display("FAIL basic_beats: got %0d want 16", nbeat); end
    n_cmp++;
    if (gap !== 1'b0) begin n_err++; $display("FAIL basic_gap: got %b want 0", gap); end
    n_cmp++;
    if (ndone !== 1) begin n_err++; $display("FAIL basic_done_cnt: got %0d want 1", ndone); end
    n_cmp++;
    if (done_cyc !== 18) begin n_err++; $display("FAIL basic_done_cyc: got %0d want 18", done_cyc); end
    n_cmp++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL basic_overflow: got %b want 0", overflow); end
  endtask

  // tready low: fill FIFO plus register, check throttle and overflow, then drain everything.
  task automatic test_fill_overflow();
    int idx = 0;
    apply_reset();
    m_axis_tready = 1'b0;
    for (int c = 0; c < 67; c++) begin
      tick();
      in_valid = (c < 66);
      in_data  = 32'(c + 1);
      @(negedge clk);
      if (c == 57) begin
        n_cmp++;
        if (in_stall !== 1'b0) begin n_err++; $display("FAIL fill_stall57: got %b want 0", in_stall); end
      end
      if (c == 58) begin
        n_cmp++;
        if (in_stall !== 1'b1) begin n_err++; $display("FAIL fill_stall58: got %b want 1", in_stall); end
      end
      if (c == 64) begin
        n_cmp++;
        if (fifo_count !== 7'd63) begin n_err++; $display("FAIL fill_count64: got %0d want 63", fifo_count); end
        n_cmp++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h1) begin
          n_err++; $display("FAIL fill_reg: got v=%b d=%h want v=1 d=1", m_axis_tvalid, m_axis_tdata);
        end
      end
      if (c == 65) begin
        n_cmp++;
        if (overflow !== 1'b0 || fifo_count !== 7'd64) begin
          n_err++; $display("FAIL fill_65th: got ovf=%b cnt=%0d want ovf=0 cnt=64", overflow, fifo_count);
        end
      end
      if (c == 66) begin
        n_cmp++;
        if (overflow !== 1'b1 || fifo_count !== 7'd64) begin
          n_err++; $display("FAIL fill_66th: got ovf=%b cnt=%0d want ovf=1 cnt=64", overflow, fifo_count);
        end
      end
    end
    for (int c = 0; c < 100; c++) begin
      tick();
      in_valid = 1'b0;
      m_axis_tready = 1'b1;
      @(negedge clk);
      if (m_axis_tvalid && m_axis_tready) begin
        n_cmp++;
        if (m_axis_tdata !== 32'(idx + 1) || m_axis_tlast !== (idx % 16 == 15)) begin
          n_err++; $display("FAIL drain[%0d]: got d=%h l=%b want d=%h l=%b",
                            idx, m_axis_tdata, m_axis_tlast, idx + 1, idx % 16 == 15);
        end
        idx++;
      end
    end
    n_cmp++;
    if (idx !== 65) begin n_err++; $display("FAIL drain_beats: got %0d want 65", idx); end
    n_cmp++;
    if (m_axis_tvalid !== 1'b0 || fifo_count !== 7'd0 || in_stall !== 1'b0) begin
      n_err++; $display("FAIL drain_empty: got v=%b cnt=%0d stall=%b want 0/0/0",
                        m_axis_tvalid, fifo_count, in_stall);
    end
  endtask

  // Random tready over three frames: AXIS stability while stalled and frame boundaries.
  task automatic test_random_ready();
    int idx = 0, ndone = 0, nlast = 0;
    bit pv = 1'b0, pr = 1'b0;
    logic [DATA_W-1:0] pd = '0;
    logic pl = 1'b0;
    apply_reset();
    for (int c = 0; c < 400 && idx < 48; c++) begin
      tick();
      in_valid = (c < 48);
      in_data  = 32'(32'h100 + c);
      m_axis_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (pv && !pr) begin
        n_cmp++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd || m_axis_tlast !== pl) begin
          n_err++; $display("FAIL rand_stable[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                            idx, m_axis_tvalid, m_axis_tdata, m_axis_tlast, pd, pl);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        n_cmp++;
        if (m_axis_tdata !== 32'(32'h100 + idx) || m_axis_tlast !== (idx % 16 == 15)) begin
          n_err++; $display("FAIL rand_beat[%0d]: got d=%h l=%b want d=%h l=%b",
                            idx, m_axis_tdata, m_axis_tlast, 32'h100 + idx, idx % 16 == 15);
        end
        if (m_axis_tlast) nlast++;
        idx++;
      end
      if (frame_done) ndone++;
      pv = m_axis_tvalid; pr = m_axis_tready; pd = m_axis_tdata; pl = m_axis_tlast;
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      in_valid = 1'b0;
      m_axis_tready = 1'b0;
      @(negedge clk);
      if (frame_done) ndone++;
    end
    n_cmp++;
    if (idx !== 48) begin n_err++; $display("FAIL rand_beats: got %0d want 48", idx); end
    n_cmp++;
    if (nlast !== 3) begin n_err++; $display("FAIL rand_tlast_cnt: got %0d want 3", nlast); end
    n_cmp++;
    if (ndone !== 3) begin n_err++; $display("FAIL rand_done_cnt: got %0d want 3", ndone); end
  endtask

  // Push and pop every cycle at occupancy 5: count constant, one beat per cycle.
  task automatic test_back_to_back();
    int nxt = 6, exp = 0;
    apply_reset();
    m_axis_tready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      in_valid = 1'b1;
      in_data  = 32'(32'h200 + c);
      @(negedge clk);
    end
    for (int c = 0; c < 200; c++) begin
      tick();
      in_valid = 1'b1;
      in_data  = 32'(32'h200 + nxt);
      nxt++;
      m_axis_tready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (fifo_count !== 7'd5) begin
        n_err++; $display("FAIL b2b_count[%0d]: got %0d want 5", c, fifo_count);
      end
      n_cmp++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'(32'h200 + exp)) begin
        n_err++; $display("FAIL b2b_beat[%0d]: got v=%b d=%h want v=1 d=%h",
                          c, m_axis_tvalid, m_axis_tdata, 32'h200 + exp);
      end
      exp++;
    end
    tick();
    in_valid = 1'b0;
    m_axis_tready = 1'b0;
  endtask

  // Asynchronous reset at beat 7 drops the partial frame; next frame counts from 0.
  task automatic test_reset_mid_frame();
    int idx = 0, ndone = 0;
    bit hit = 1'b0;
    apply_reset();
    m_axis_tready = 1'b1;
    for (int c = 0; c < 40 && !hit; c++) begin
      tick();
      in_valid = (c < 20);
      in_data  = 32'(32'h400 + c);
      @(negedge clk);
      if (m_axis_tvalid) begin
        if (idx == 7) begin
          hit = 1'b1;
          n_cmp++;
          if (m_axis_tdata !== 32'h407) begin
            n_err++; $display("FAIL mid_beat7: got %h want 407", m_axis_tdata);
          end
          rst_n = 1'b0;
          in_valid = 1'b0;
          #1;
          n_cmp++;
          if ({m_axis_tvalid, m_axis_tlast, frame_done, overflow, in_stall} !== 5'b0 ||
              m_axis_tdata !== 32'h0 || fifo_count !== 7'd0) begin
            n_err++; $display("FAIL mid_async: got v=%b l=%b fd=%b ovf=%b st=%b d=%h cnt=%0d want all 0",
                              m_axis_tvalid, m_axis_tlast, frame_done, overflow, in_stall,
                              m_axis_tdata, fifo_count);
          end
        end else begin
          idx++;
        end
      end
    end
    n_cmp++;
    if (hit !== 1'b1) begin n_err++; $display("FAIL mid_reach7: got %b want 1", hit); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      in_valid = (c < 16);
      in_data  = 32'(32'h500 + c);
      @(negedge clk);
      if (m_axis_tvalid) begin
        n_cmp++;
        if (m_axis_tdata !== 32'(32'h500 + idx) || m_axis_tlast !== (idx == 15)) begin
          n_err++; $display("FAIL mid_next[%0d]: got d=%h l=%b want d=%h l=%b",
                            idx, m_axis_tdata, m_axis_tlast, 32'h500 + idx, idx == 15);
        end
        idx++;
      end
      if (frame_done) ndone++;
    end
    n_cmp++;
    if (idx !== 16 || ndone !== 1) begin
      n_err++; $display("FAIL mid_next_frame: got beats=%0d done=%0d want 16/1", idx, ndone);
    end
  endtask

  // Clear coinciding with a new overflow loses; a clear on its own wins.
  task automatic test_overflow_clear();
    apply_reset();
    m_axis_tready = 1'b0;
    for (int c = 0; c < 65; c++) begin
      tick();
      in_valid = 1'b1;
      in_data  = 32'(32'h600 + c);
      @(negedge clk);
    end
    tick();
    in_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (fifo_count !== 7'd64 || overflow !== 1'b0) begin
      n_err++; $display("FAIL ovc_full: got cnt=%0d ovf=%b want 64/0", fifo_count, overflow);
    end
    tick();
    in_valid = 1'b1;
    clear_overflow = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (overflow !== 1'b1) begin n_err++; $display("FAIL ovc_set: got %b want 1", overflow); end
    tick();
    in_valid = 1'b0;
    clear_overflow = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (overflow !== 1'b1) begin n_err++; $display("FAIL ovc_set_wins: got %b want 1", overflow); end
    tick();
    clear_overflow = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL ovc_cleared: got %b want 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_fill_overflow();
    test_random_ready();
    test_back_to_back();
    test_reset_mid_frame();
    test_overflow_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
